dsp_cfg_mgmt_arbiter: RTL

DSP_CFG_MGMT_ARBITER -- requirements
Module: dsp_cfg_mgmt_arbiter

---
 rtl/dsp_cfg_mgmt_pkg.sv | 42 ++++
 rtl/dsp_cfg_mgmt_arbiter_if.sv | 27 ++
 rtl/dsp_cfg_mgmt_arbiter_rr.sv | 24 ++
 rtl/dsp_cfg_mgmt_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/dsp_cfg_mgmt_pkg.sv
// Shared types and widths for the DSP cfg_mgmt arbiter: FSM state, latched request
// record and a helper that slices one requester out of the flattened request bus.
package dsp_cfg_mgmt_pkg;
   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 10;
   localparam int FN_W    = 16;
   localparam int DATA_W  = 32;
   localparam int BE_W    = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [FN_W-1:0]   function_number;
      logic [DATA_W-1:0] write_data;
      logic [BE_W-1:0]   byte_enable;
   } req_t;

   function automatic req_t pick_req(
      input logic [NUM_REQ-1:0]        write,
      input logic [NUM_REQ*ADDR_W-1:0] addr,
      input logic [NUM_REQ*FN_W-1:0]   function_number,
      input logic [NUM_REQ*DATA_W-1:0] write_data,
      input logic [NUM_REQ*BE_W-1:0]   byte_enable,
      input logic                      idx
   );
      req_t r;
      int unsigned n;
      n                 = int'(idx);
      r.write           = write[n];
      r.addr            = addr[n*ADDR_W +: ADDR_W];
      r.function_number = function_number[n*FN_W +: FN_W];
      r.write_data      = write_data[n*DATA_W +: DATA_W];
      r.byte_enable     = byte_enable[n*BE_W +: BE_W];
      return r;
   endfunction
endpackage

// File: rtl/dsp_cfg_mgmt_arbiter_if.sv
// Requester-side bundle of the cfg_mgmt arbiter: request handshake plus completion.
// master = requesters, slave = arbiter.
interface dsp_cfg_mgmt_arbiter_if;
   import dsp_cfg_mgmt_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*FN_W-1:0]   req_function_number;
   logic [NUM_REQ*DATA_W-1:0] req_write_data;
   logic [NUM_REQ*BE_W-1:0]   req_byte_enable;
   logic                      rsp_valid;
   logic                      rsp_id;
   logic [DATA_W-1:0]         rsp_read_data;
   logic                      rsp_error;

   modport master (
      output req_valid, req_write, req_addr, req_function_number, req_write_data, req_byte_enable,
      input  req_ready, rsp_valid, rsp_id, rsp_read_data, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_function_number, req_write_data, req_byte_enable,
      output req_ready, rsp_valid, rsp_id, rsp_read_data, rsp_error
   );
endinterface

// File: rtl/dsp_cfg_mgmt_arbiter_rr.sv
// Two-way round-robin grant with last-grant pointer; the pointer resets to 1 so
// requester 0 wins the first contested grant.
module rr_arbiter_2 (
   input  logic       dsp_user_clk,
   input  logic       sys_reset_n,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant,
   output logic       grant_id
);
   logic last;

   always_comb begin
      grant_id = valid[1];
      if (valid == 2'b11) grant_id = ~last;
      grant = 2'b00;
      if (en && (valid != 2'b00)) grant = grant_id ? 2'b10 : 2'b01;
   end

   always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) last <= 1'b1;
      else if (en && (valid != 2'b00)) last <= grant_id;
   end
endmodule

// File: rtl/dsp_cfg_mgmt_arbiter.sv
// Arbitrates two requesters onto the DSP cfg_mgmt port and returns one completion per access.
// Optional access timeout: define CFG_MGMT_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | waiting for a request; grant and latch fields on any req_valid
// S_ACCESS | strobe held with latched fields until done (or timeout)
// S_RESP   | one-cycle rsp_valid pulse, then back to S_IDLE
module dsp_cfg_mgmt_arbiter
   import dsp_cfg_mgmt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 dsp_user_clk,
   input  logic                 sys_reset_n,
   dsp_cfg_mgmt_arbiter_if.slave req_if,
   output logic                 dsp_cfg_mgmt_write,
   output logic                 dsp_cfg_mgmt_read,
   output logic [ADDR_W-1:0]    dsp_cfg_mgmt_addr,
   output logic [FN_W-1:0]      dsp_cfg_mgmt_function_number,
   output logic [DATA_W-1:0]    dsp_cfg_mgmt_write_data,
   output logic [BE_W-1:0]      dsp_cfg_mgmt_byte_enable,
   input  logic [DATA_W-1:0]    dsp_cfg_mgmt_read_data,
   input  logic                 dsp_cfg_mgmt_read_write_done
);
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 2..65535");
   end

   state_t            state, state_nxt;
   req_t              req_q;
   logic              rsp_id_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [1:0]        grant;
   logic              grant_id;
   logic              idle, access, resp, done, expire;

   assign idle   = (state == S_IDLE);
   assign access = (state == S_ACCESS);
   assign resp   = (state == S_RESP);
   assign done   = access && dsp_cfg_mgmt_read_write_done;

   rr_arbiter_2 u_arb (
      .dsp_user_clk (dsp_user_clk),
      .sys_reset_n  (sys_reset_n),
      .en           (idle),
      .valid        (req_if.req_valid),
      .grant        (grant),
      .grant_id     (grant_id)
   );

`ifdef CFG_MGMT_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        rsp_err_q;

   assign expire = access && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         tmo_cnt   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (access) tmo_cnt <= tmo_cnt + 16'd1;
         else        tmo_cnt <= '0;
         // done in the expiry cycle wins over the timeout
         if (done)        rsp_err_q <= 1'b0;
         else if (expire) rsp_err_q <= 1'b1;
      end
   end

   assign req_if.rsp_error = resp && rsp_err_q;
`else
   assign expire           = 1'b0;
   assign req_if.rsp_error = 1'b0;
`endif

   always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) state <= S_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (grant != 2'b00) state_nxt = S_ACCESS;
         S_ACCESS: if (done || expire) state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         req_q      <= '0;
         rsp_id_q   <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         if (grant != 2'b00) begin
            req_q    <= pick_req(req_if.req_write, req_if.req_addr, req_if.req_function_number,
                                 req_if.req_write_data, req_if.req_byte_enable, grant_id);
            rsp_id_q <= grant_id;
         end
         if (done)        rsp_data_q <= req_q.write ? '0 : dsp_cfg_mgmt_read_data;
         else if (expire) rsp_data_q <= '0;
      end
   end

   assign req_if.req_ready = grant;

   assign dsp_cfg_mgmt_write           = access &&  req_q.write;
   assign dsp_cfg_mgmt_read            = access && !req_q.write;
   assign dsp_cfg_mgmt_addr            = access ? req_q.addr            : '0;
   assign dsp_cfg_mgmt_function_number = access ? req_q.function_number : '0;
   assign dsp_cfg_mgmt_write_data      = access ? req_q.write_data      : '0;
   assign dsp_cfg_mgmt_byte_enable     = access ? req_q.byte_enable     : '0;

   assign req_if.rsp_valid     = resp;
   assign req_if.rsp_id        = resp && rsp_id_q;
   assign req_if.rsp_read_data = resp ? rsp_data_q : '0;
endmodule
